// File: rtl/uart_tx_framed.sv
// UART transmitter with one-word holding register and configurable framing.
// Line changes only on bit-rate ticks; back-to-back frames need no idle bits.
module uart_tx_framed #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clk_tx,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_txd,
    output logic                 o_busy,
    output logic                 o_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] hold;
    logic [DATA_BITS-1:0] shreg;
    logic                 hold_full;
    logic                 par;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic                 last_bit;
    logic                 last_stop;

    assign last_bit  = (bit_cnt == 4'(DATA_BITS - 1));
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
    assign o_ready   = ~hold_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            o_txd     <= 1'b1;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            hold_full <= 1'b0;
            hold      <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            // Accept needs hold_full=0, reload needs hold_full=1: never both.
            if (i_valid && !hold_full) begin
                hold      <= i_data;
                hold_full <= 1'b1;
            end
            if (i_clk_tx) begin
                unique case (state)
                    IDLE: begin
                        if (hold_full) begin
                            shreg     <= hold;
                            hold_full <= 1'b0;
                            o_txd     <= 1'b0;
                            o_busy    <= 1'b1;
                            state     <= START;
                        end
                    end
                    START: begin
                        o_txd   <= shreg[0];
                        shreg   <= shreg >> 1;
                        par     <= (^shreg) ^ (PARITY_ODD != 0);
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                    DATA: begin
                        if (!last_bit) begin
                            o_txd   <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (PARITY_EN != 0) begin
                            o_txd <= par;
                            state <= PARITY;
                        end else begin
                            o_txd    <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= STOP;
                        end
                    end
                    PARITY: begin
                        o_txd    <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                    STOP: begin
                        if (!last_stop) begin
                            stop_cnt <= stop_cnt + 1'b1;
                            o_txd    <= 1'b1;
                        end else begin
                            o_done <= 1'b1;
                            if (hold_full) begin
                                shreg     <= hold;
                                hold_full <= 1'b0;
                                o_txd     <= 1'b0;
                                state     <= START;
                            end else begin
                                o_txd  <= 1'b1;
                                o_busy <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Scoreboard bench for uart_tx_framed: four framing variants share one
// tick; a monitor pops the expected line pattern on every o_done.
module tb_uart_tx_framed;

    typedef struct {
        int          k;
        logic [15:0] frame;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic tick = 1'b0;
    int   div  = 0;

    logic       rst   [4];
    logic       valid [4];
    logic [8:0] data  [4];
    logic       ready [4];
    logic       txd   [4];
    logic       busy  [4];
    logic       done  [4];

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int          tick_no = 0;
    logic [31:0] hist [4];
    int          done_cnt [4];
    int          last_done [4];
    int          gap [4];
    int          len [4] = '{10, 11, 11, 10};

    uart_tx_framed u0 (
        .clk(clk), .reset(rst[0]), .i_clk_tx(tick), .i_valid(valid[0]),
        .i_data(data[0][7:0]), .o_ready(ready[0]), .o_txd(txd[0]),
        .o_busy(busy[0]), .o_done(done[0])
    );

    uart_tx_framed #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .reset(rst[1]), .i_clk_tx(tick), .i_valid(valid[1]),
        .i_data(data[1][7:0]), .o_ready(ready[1]), .o_txd(txd[1]),
        .o_busy(busy[1]), .o_done(done[1])
    );

    uart_tx_framed #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .reset(rst[2]), .i_clk_tx(tick), .i_valid(valid[2]),
        .i_data(data[2][7:0]), .o_ready(ready[2]), .o_txd(txd[2]),
        .o_busy(busy[2]), .o_done(done[2])
    );

    uart_tx_framed #(.DATA_BITS(7), .STOP_BITS(2)) u3 (
        .clk(clk), .reset(rst[3]), .i_clk_tx(tick), .i_valid(valid[3]),
        .i_data(data[3][6:0]), .o_ready(ready[3]), .o_txd(txd[3]),
        .o_busy(busy[3]), .o_done(done[3])
    );

    // Tick every 16 clocks, changed on the falling edge.
    always @(negedge clk) begin
        if (div == 15) begin
            tick = 1'b1;
            div  = 0;
        end else begin
            tick = 1'b0;
            div  = div + 1;
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    always @(posedge clk) begin : monitor
        exp_t        e;
        logic [31:0] m;
        #1;
        if (tick) tick_no++;
        for (int k = 0; k < 4; k++) begin
            if (done[k] === 1'b1) begin
                chk($sformatf("done_on_tick_dut%0d", k), 32'(tick), 1);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done dut=%0d got=1 want=0", k);
                end else begin
                    e = sbq.pop_front();
                    m = (32'd1 << len[k]) - 32'd1;
                    chk($sformatf("frame_dut%0d", k), 32'(k), 32'(e.k));
                    chk($sformatf("frame_bits_dut%0d", k), hist[k] & m,
                        32'(e.frame));
                end
                gap[k]       = tick_no - last_done[k];
                last_done[k] = tick_no;
                done_cnt[k]++;
            end
            if (tick) hist[k] = {hist[k][30:0], txd[k]};
        end
    end

    task automatic send(int k, logic [8:0] d, logic [15:0] f, bit push);
        int   n;
        exp_t e;
        n = 0;
        while (ready[k] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout dut=%0d got=ready0 want=ready1", k);
        end
        if (push) begin
            e.k     = k;
            e.frame = f;
            sbq.push_back(e);
        end
        valid[k] = 1'b1;
        data[k]  = d;
        @(negedge clk);
        valid[k] = 1'b0;
        data[k]  = ~d;
    endtask

    task automatic measure_busy(int k, output int n);
        int w;
        w = 0;
        n = 0;
        while (busy[k] !== 1'b1 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        while (busy[k] === 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (w >= 4000 || n >= 4000) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout dut=%0d got=w%0d_n%0d want=bounded",
                     k, w, n);
        end
    endtask

    initial begin : stim
        int n;
        int c0;
        int t0;
        int w;
        for (int k = 0; k < 4; k++) begin
            rst[k]       = 1'b1;
            valid[k]     = 1'b0;
            data[k]      = '0;
            hist[k]      = '0;
            done_cnt[k]  = 0;
            last_done[k] = 0;
            gap[k]       = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd[0]), 1);
        chk("rst_ready", 32'(ready[0]), 1);
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_done", 32'(done[0]), 0);
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("rst_txd_dut%0d", k), 32'(txd[k]), 1);
            chk($sformatf("rst_ready_dut%0d", k), 32'(ready[k]), 1);
        end
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;

        // Idle ticks leave the line high.
        repeat (4) begin
            repeat (16) @(negedge clk);
            chk("idle_txd", 32'(txd[0]), 1);
            chk("idle_busy", 32'(busy[0]), 0);
        end
        chk("idle_no_done", 32'(done_cnt[0]), 0);

        // 0xA5, 8N1
        fork
            send(0, 9'h0A5, 16'b0101001011, 1);
            measure_busy(0, n);
        join
        chk("a5_busy_clks", 32'(n), 160);
        chk("a5_done_cnt", 32'(done_cnt[0]), 1);

        // 0xA5 with even and odd parity
        fork
            send(1, 9'h0A5, 16'b01010010101, 1);
            measure_busy(1, n);
        join
        chk("even_busy_clks", 32'(n), 176);
        send(2, 9'h0A5, 16'b01010010111, 1);
        measure_busy(2, n);
        chk("odd_done_cnt", 32'(done_cnt[2]), 1);

        // 7 data bits, 2 stop bits, back-to-back
        fork
            begin
                send(3, 9'h041, 16'b0100000111, 1);
                send(3, 9'h07F, 16'b0111111111, 1);
            end
            measure_busy(3, n);
        join
        chk("b2b_busy_clks", 32'(n), 320);
        chk("b2b_done_cnt", 32'(done_cnt[3]), 2);
        chk("b2b_done_gap", 32'(gap[3]), 10);

        // Requests while full are ignored.
        c0 = done_cnt[0];
        send(0, 9'h03C, 16'b0001111001, 1);
        send(0, 9'h05A, 16'b0010110101, 1);
        n = 0;
        while (ready[0] !== 1'b1 && n < 2000) begin
            valid[0] = 1'b1;
            data[0]  = 9'h0FF;
            @(negedge clk);
            n++;
        end
        valid[0] = 1'b0;
        measure_busy(0, n);
        repeat (64) @(negedge clk);
        chk("flood_done_cnt", 32'(done_cnt[0] - c0), 2);
        chk("flood_idle_ready", 32'(ready[0]), 1);

        // Reset during data bit 3 with a word held.
        c0 = done_cnt[0];
        send(0, 9'h0C3, 16'h0, 0);
        w = 0;
        while (busy[0] !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        t0 = tick_no;
        send(0, 9'h081, 16'h0, 0);
        chk("held_ready", 32'(ready[0]), 0);
        w = 0;
        while (tick_no < t0 + 4 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("bit3_txd", 32'(txd[0]), 0);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("abort_txd", 32'(txd[0]), 1);
        chk("abort_ready", 32'(ready[0]), 1);
        chk("abort_busy", 32'(busy[0]), 0);
        rst[0] = 1'b0;
        repeat (48) @(negedge clk);
        chk("abort_idle_txd", 32'(txd[0]), 1);
        chk("abort_no_done", 32'(done_cnt[0] - c0), 0);
        send(0, 9'h096, 16'b0011010011, 1);
        measure_busy(0, n);
        chk("after_abort_done", 32'(done_cnt[0] - c0), 1);

        repeat (20) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
